fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have parameter XLEN, default 64, meaning the PC and address width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 4, meaning the fetch-buffer entries (power of two, 2..16).
REQ-003 The module SHALL have parameter RESET_PC, default 0, meaning the first fetch address after reset.
REQ-004 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit, the asynchronous active-high reset.
REQ-006 The module SHALL have port RedirectD, input, 1 bit, a branch/jump taken in decode (the PCSrcD|JalD equivalent).
REQ-007 The module SHALL have port PCTargetD, input, XLEN bits, the redirect target address.
REQ-008 The module SHALL have port imem_req_valid, output, 1 bit, an instruction fetch request.
REQ-009 The module SHALL have port imem_req_ready, input, 1 bit; the request is accepted when both valid and ready are 1.
REQ-010 The module SHALL have port imem_addr, output, XLEN bits, the request byte address.
REQ-011 The module SHALL have port imem_rsp_valid, input, 1 bit, a returned instruction; responses arrive in request order, at least 1 cycle after acceptance, and are never back-pressured.
REQ-012 The module SHALL have port imem_rsp_data, input, 32 bits, the returned instruction word.
REQ-013 The module SHALL have port ReadyD, input, 1 bit; decode consumes the head entry (0 = stall).
REQ-014 The module SHALL have port ValidD, output, 1 bit, indicating InstrD/PCD/PCPlus4D are valid.
REQ-015 The module SHALL have port InstrD, output, 32 bits, the head instruction.
REQ-016 The module SHALL have port PCD, output, XLEN bits, the head instruction address.
REQ-017 The module SHALL have port PCPlus4D, output, XLEN bits, equal to PCD+4.

Function
REQ-018 The module SHALL hold a fetch PC register (PCF) and a circular buffer of DEPTH entries {pc, instr, filled}, managed by three pointers: tail (allocate), fill (response), and head (pop).
REQ-019 The module SHALL assert imem_req_valid when the buffer is not full (allocated entries < DEPTH) and no redirect is present that cycle; imem_addr SHALL equal PCF.
REQ-020 On request acceptance the module SHALL write an entry {pc=PCF, filled=0} at tail, advance tail, and set PCF to PCF+4.
REQ-021 On imem_rsp_valid with drop count 0, the module SHALL write imem_rsp_data to the entry at fill, set filled=1, and advance fill.
REQ-022 ValidD SHALL be 1 exactly when the head entry is allocated and filled; the outputs SHALL present that entry combinationally, with no extra registering.
REQ-023 On a cycle with ValidD=1 and ReadyD=1 the module SHALL pop the head entry; a filled entry waiting for decode SHALL reach decode with 0 cycles of latency.
REQ-024 With a zero-wait memory and ReadyD held at 1, the module SHALL sustain one instruction per cycle.
REQ-025 On RedirectD=1 the module SHALL set PCF to {PCTargetD[XLEN-1:2],2'b00}, empty the buffer (all pointers equal), force ValidD low that cycle, suppress any pop, and issue no request that cycle.
REQ-026 On a redirect the module SHALL load the drop count with the number of accepted-but-unanswered requests; an imem_rsp_valid arriving in the redirect cycle SHALL be counted as dropped.
REQ-027 While the drop count is nonzero, each imem_rsp_valid SHALL decrement the count and its data SHALL be discarded.
REQ-028 Requests to the new PC MAY issue during the drop window, because responses are in order and drops precede new data.
REQ-029 When the buffer is full, the module SHALL deassert imem_req_valid; a pop in the same cycle SHALL free its slot for request the following cycle, not combinationally.
REQ-030 All pointer, PC, and PC+4 arithmetic SHALL wrap modulo DEPTH and modulo 2^XLEN respectively; at PCF = 2^XLEN-4 the next PCF SHALL be 0.
REQ-031 The outstanding count SHALL never exceed DEPTH; an imem_rsp_valid with no outstanding request is illegal and is a verification assertion, not handled behaviour.

Reset
REQ-032 While rst=1 the module SHALL asynchronously set PCF=RESET_PC, all pointers=0, drop count=0, and all filled bits=0.
REQ-033 While rst=1 the outputs SHALL be: ValidD=0, imem_req_valid=0, InstrD=0, PCD=0, PCPlus4D=0.
REQ-034 The first request after deassertion SHALL carry imem_addr=RESET_PC.
REQ-035 A reset asserted mid-operation SHALL discard all in-flight responses; the environment SHALL reset the memory concurrently.
REQ-036 rst SHALL take priority over RedirectD.

Verification
REQ-037 Scenario streaming: RESET_PC=0, memory with 1-cycle latency, ReadyD=1 -> PCD sequence 0,4,8,... one per cycle, with PCPlus4D=PCD+4.
REQ-038 Scenario stall/full: ReadyD=0 for 10 cycles -> exactly DEPTH requests issued and imem_req_valid then held at 0; ReadyD=1 -> DEPTH entries pop in order with no loss.
REQ-039 Scenario redirect with in-flight requests: memory latency 3, RedirectD=1 with PCTargetD=0x103 while 2 requests are outstanding -> the 2 responses are dropped and the next ValidD presents PCD=0x100.
REQ-040 Scenario redirect with coincident response: RedirectD and imem_rsp_valid in the same cycle -> the response is dropped, the drop count is correct, and no stale instruction reaches decode.
REQ-041 Scenario wrap-around: RESET_PC=2^XLEN-8 -> PCD values 2^XLEN-8, 2^XLEN-4, 0, and PCPlus4D=0 at PCD=2^XLEN-4.
REQ-042 Scenario reset mid-stream: rst pulsed asynchronously between clock edges with a full buffer -> outputs are 0 immediately, and after release the first imem_addr is RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with a circular buffer and redirect response dropping
module fetch_unit #(
  parameter int XLEN = 64,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RedirectD,
  input  logic [XLEN-1:0] PCTargetD,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            ReadyD,
  output logic            ValidD,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D
);
  localparam int AW = $clog2(DEPTH);
  logic [XLEN-1:0] pcf;
  logic [XLEN-1:0] pc_q [DEPTH];
  logic [31:0] instr_q [DEPTH];
  logic [DEPTH-1:0] filled;
  logic [AW:0] tail, fill, head, drop, count, pend;
  logic [AW+1:0] busy;
  logic accept, take, pop;
  assign count = tail - head;
  assign pend = tail - fill;
  // Dropped responses still occupy the memory, so they count against the outstanding limit
  assign busy = {1'b0, count} + {1'b0, drop};
  assign imem_req_valid = !rst && !RedirectD && busy < (AW+2)'(DEPTH);
  assign imem_addr = pcf;
  assign accept = imem_req_valid && imem_req_ready;
  assign take = !rst && !RedirectD && imem_rsp_valid && drop == '0;
  assign ValidD = !RedirectD && count != '0 && filled[head[AW-1:0]];
  assign pop = ValidD && ReadyD;
  assign InstrD = ValidD ? instr_q[head[AW-1:0]] : '0;
  assign PCD = ValidD ? pc_q[head[AW-1:0]] : '0;
  assign PCPlus4D = ValidD ? pc_q[head[AW-1:0]] + XLEN'(4) : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcf <= RESET_PC;
      tail <= '0;
      fill <= '0;
      head <= '0;
      drop <= '0;
      filled <= '0;
    end else if (RedirectD) begin
      pcf <= PCTargetD & ~XLEN'(3);
      head <= tail;
      fill <= tail;
      drop <= drop + pend - {{AW{1'b0}}, imem_rsp_valid};
    end else begin
      if (accept) begin
        filled[tail[AW-1:0]] <= 1'b0;
        tail <= tail + 1'b1;
        pcf <= pcf + XLEN'(4);
      end
      if (imem_rsp_valid && drop != '0)
        drop <= drop - 1'b1;
      if (take) begin
        filled[fill[AW-1:0]] <= 1'b1;
        fill <= fill + 1'b1;
      end
      if (pop)
        head <= head + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (accept)
      pc_q[tail[AW-1:0]] <= pcf;
    if (take)
      instr_q[fill[AW-1:0]] <= imem_rsp_data;
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a fixed-latency in-order memory model
module tb_fetch_unit;
  logic clk = 0;
  logic rst;
  logic redirect [2];
  logic [63:0] target [2];
  logic req_valid [2];
  logic req_ready [2];
  logic [63:0] addr [2];
  logic rsp_valid [2];
  logic [31:0] rsp_data [2];
  logic rdy [2];
  logic valid [2];
  logic [31:0] instr [2];
  logic [63:0] pcd [2];
  logic [63:0] pc4 [2];
  int errors = 0;
  int checks = 0;
  int lat [2];
  int acc_cnt [2];
  int cnt = 0;
  logic [63:0] qa [2][$];
  int qd [2][$];
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam logic [31:0] K = 32'h1357_9BDF;

  always #5 clk = ~clk;

  fetch_unit u0 (.clk(clk), .rst(rst), .RedirectD(redirect[0]), .PCTargetD(target[0]),
    .imem_req_valid(req_valid[0]), .imem_req_ready(req_ready[0]), .imem_addr(addr[0]),
    .imem_rsp_valid(rsp_valid[0]), .imem_rsp_data(rsp_data[0]), .ReadyD(rdy[0]),
    .ValidD(valid[0]), .InstrD(instr[0]), .PCD(pcd[0]), .PCPlus4D(pc4[0]));

  fetch_unit #(.RESET_PC(WRAP_PC)) u1 (.clk(clk), .rst(rst), .RedirectD(redirect[1]),
    .PCTargetD(target[1]), .imem_req_valid(req_valid[1]), .imem_req_ready(req_ready[1]),
    .imem_addr(addr[1]), .imem_rsp_valid(rsp_valid[1]), .imem_rsp_data(rsp_data[1]),
    .ReadyD(rdy[1]), .ValidD(valid[1]), .InstrD(instr[1]), .PCD(pcd[1]), .PCPlus4D(pc4[1]));

  always @(posedge clk) begin
    cnt = cnt + 1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        qa[i].delete();
        qd[i].delete();
      end else begin
        if (rsp_valid[i]) begin
          void'(qa[i].pop_front());
          void'(qd[i].pop_front());
        end
        if (req_valid[i] && req_ready[i]) begin
          qa[i].push_back(addr[i]);
          qd[i].push_back(cnt + lat[i]);
          acc_cnt[i] = acc_cnt[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst && qa[i].size() > 0 && qd[i][0] <= cnt + 1) begin
        rsp_valid[i] = 1'b1;
        rsp_data[i] = qa[i][0][31:0] ^ K;
      end else begin
        rsp_valid[i] = 1'b0;
        rsp_data[i] = '0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic zero_outputs(input string tag);
    check({tag, "_valid"}, 64'(valid[0]), 0);
    check({tag, "_req"}, 64'(req_valid[0]), 0);
    check({tag, "_instr"}, 64'(instr[0]), 0);
    check({tag, "_pcd"}, pcd[0], 0);
    check({tag, "_pc4"}, pc4[0], 0);
  endtask

  task automatic wait_valid(input string tag, input logic [63:0] pc);
    int n = 0;
    while (!valid[0] && n < 20) begin
      tick;
      n++;
    end
    check({tag, "_timeout"}, 64'(n < 20), 1);
    check({tag, "_pcd"}, pcd[0], pc);
    check({tag, "_instr"}, 64'(instr[0]), 64'(pc[31:0] ^ K));
  endtask

  task automatic restart(input int l, input logic r);
    rst = 1'b1;
    lat[0] = l;
    tick;
    rst = 1'b0;
    rdy[0] = r;
  endtask

  initial begin
    int a0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      redirect[i] = 1'b0;
      target[i] = '0;
      req_ready[i] = 1'b1;
      rdy[i] = 1'b1;
      lat[i] = 1;
      acc_cnt[i] = 0;
      rsp_valid[i] = 1'b0;
      rsp_data[i] = '0;
    end
    repeat (3) tick;
    zero_outputs("reset");
    check("reset_valid1", 64'(valid[1]), 0);
    rst = 1'b0;
    #1;
    check("first_addr", addr[0], 0);
    check("first_req", 64'(req_valid[0]), 1);
    check("wrap_first_addr", addr[1], WRAP_PC);
    tick;
    tick;
    for (int k = 0; k < 6; k++) begin
      check("stream_valid", 64'(valid[0]), 1);
      check("stream_pcd", pcd[0], 64'(4 * k));
      check("stream_pc4", pc4[0], 64'(4 * k + 4));
      check("stream_instr", 64'(instr[0]), 64'((4 * k) ^ K));
      if (k < 3) begin
        check("wrap_valid", 64'(valid[1]), 1);
        check("wrap_pcd", pcd[1], WRAP_PC + 64'(4 * k));
        check("wrap_pc4", pc4[1], WRAP_PC + 64'(4 * k + 4));
      end
      tick;
    end

    restart(1, 1'b0);
    a0 = acc_cnt[0];
    repeat (10) tick;
    check("full_accepts", 64'(acc_cnt[0] - a0), 4);
    check("full_req", 64'(req_valid[0]), 0);
    check("full_head", pcd[0], 0);
    rdy[0] = 1'b1;
    #1;
    check("full_pop_req", 64'(req_valid[0]), 0);
    for (int k = 0; k < 5; k++) begin
      check("drain_valid", 64'(valid[0]), 1);
      check("drain_pcd", pcd[0], 64'(4 * k));
      tick;
    end

    restart(1, 1'b0);
    repeat (8) tick;
    check("pre_rst_valid", 64'(valid[0]), 1);
    #2 rst = 1'b1;
    #1 zero_outputs("async_rst");
    tick;
    rst = 1'b0;
    #1;
    check("post_rst_addr", addr[0], 0);
    check("post_rst_req", 64'(req_valid[0]), 1);
    wait_valid("post_rst", 64'h0);

    restart(3, 1'b1);
    tick;
    tick;
    check("inflight_accepts", 64'(qa[0].size()), 2);
    redirect[0] = 1'b1;
    target[0] = 64'h103;
    #1;
    check("redir_valid", 64'(valid[0]), 0);
    check("redir_req", 64'(req_valid[0]), 0);
    tick;
    redirect[0] = 1'b0;
    #1;
    check("redir_addr", addr[0], 64'h100);
    wait_valid("redir", 64'h100);

    restart(1, 1'b0);
    tick;
    tick;
    check("coin_head_valid", 64'(valid[0]), 1);
    check("coin_head_pcd", pcd[0], 0);
    rdy[0] = 1'b1;
    redirect[0] = 1'b1;
    target[0] = 64'h200;
    #1;
    check("coin_forced_low", 64'(valid[0]), 0);
    tick;
    redirect[0] = 1'b0;
    wait_valid("coin", 64'h200);
    tick;
    check("coin_next_pcd", pcd[0], 64'h204);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
